// File: rtl/candy_sram_ctrl_pkg.sv
// Shared types and constants for the candy SRAM controller: FSM states, request source,
// and wait-counter sizing.
package candy_sram_ctrl_pkg;

    localparam int unsigned CntW = 4;

    typedef enum logic [1:0] {
        SramIdle = 2'b00,
        SramRd   = 2'b01,
        SramWr   = 2'b10,
        SramDone = 2'b11
    } sram_state_e;

    typedef enum logic {
        SrcIf  = 1'b0,
        SrcMem = 1'b1
    } sram_src_e;

    // Counter load value: the access state lasts cycles counts, ending when the counter hits 0.
    function automatic logic [CntW-1:0] wait_load(input int unsigned cycles);
        return CntW'(cycles - 1);
    endfunction

endpackage

// File: rtl/candy_sram_waitcnt.sv
// Loadable 4-bit down-counter with a zero flag; timing for SRAM wait states.
module candy_sram_waitcnt
    import candy_sram_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_load,
    input  logic [CntW-1:0] i_load_val,
    input  logic            i_dec,
    output logic            o_zero
);

    logic [CntW-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CntW'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/candy_sram_ctrl.sv
// Single-port asynchronous SRAM controller arbitrating instruction fetch (IF) and
// memory-stage (MEM) requests, MEM having fixed priority.
module candy_sram_ctrl
    import candy_sram_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ADDR_W      = 17,
    parameter int unsigned DATA_W      = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_read_enable,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_is_mem,
    input  logic              mem_read_enable,
    input  logic              mem_write_enable,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] if_data,
    output logic              if_data_ready,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_data_ready,
    output logic              busy,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    input  logic [DATA_W-1:0] sram_dq_i,
    output logic [DATA_W-1:0] sram_dq_o,
    output logic              sram_dq_oe
);

    localparam logic [CntW-1:0] LoadVal    = wait_load(WAIT_CYCLES);
    localparam logic            SingleWait = (WAIT_CYCLES == 1);

    sram_state_e       r_state, w_state_next;
    sram_src_e         r_src, w_start_src;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_if_data, r_mem_rdata;
    logic              w_start, w_capture, w_cnt_dec, w_cnt_zero;

    candy_sram_waitcnt u_waitcnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_start),
        .i_load_val (LoadVal),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= SramIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_start        = 1'b0;
        w_start_src    = SrcIf;
        w_capture      = 1'b0;
        w_cnt_dec      = 1'b0;
        sram_ce_n      = 1'b1;
        sram_oe_n      = 1'b1;
        sram_we_n      = 1'b1;
        sram_dq_oe     = 1'b0;
        if_data_ready  = 1'b0;
        mem_data_ready = 1'b0;
        unique case (r_state)
            SramIdle: begin
                if (mem_write_enable) begin
                    w_state_next = SramWr;
                    w_start      = 1'b1;
                    w_start_src  = SrcMem;
                end else if (mem_read_enable) begin
                    w_state_next = SramRd;
                    w_start      = 1'b1;
                    w_start_src  = SrcMem;
                end else if (if_read_enable && !if_is_mem) begin
                    w_state_next = SramRd;
                    w_start      = 1'b1;
                    w_start_src  = SrcIf;
                end
            end
            SramRd: begin
                sram_ce_n = 1'b0;
                sram_oe_n = 1'b0;
                if (w_cnt_zero) begin
                    w_capture    = 1'b1;
                    w_state_next = SramDone;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            SramWr: begin
                sram_ce_n  = 1'b0;
                sram_dq_oe = 1'b1;
                // Release WE one cycle early for data hold, unless the write is a single cycle.
                sram_we_n  = !(!w_cnt_zero || SingleWait);
                if (w_cnt_zero) begin
                    w_state_next = SramDone;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            SramDone: begin
                if_data_ready  = (r_src == SrcIf);
                mem_data_ready = (r_src == SrcMem);
                w_state_next   = SramIdle;
            end
            default: w_state_next = SramIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_src       <= SrcIf;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_if_data   <= '0;
            r_mem_rdata <= '0;
        end else begin
            if (w_start) begin
                r_src   <= w_start_src;
                r_addr  <= (w_start_src == SrcMem) ? mem_addr : if_addr;
                r_wdata <= mem_wdata;
            end
            if (w_capture) begin
                if (r_src == SrcMem) begin
                    r_mem_rdata <= sram_dq_i;
                end else begin
                    r_if_data <= sram_dq_i;
                end
            end
        end
    end

    assign busy        = (r_state != SramIdle);
    assign sram_addr_o = r_addr;
    assign sram_dq_o   = r_wdata;
    assign if_data     = r_if_data;
    assign mem_rdata   = r_mem_rdata;

endmodule

// File: tb/tb_candy_sram_ctrl.sv
// Directed, cycle-exact bench for candy_sram_ctrl with WAIT_CYCLES=2.
module tb_candy_sram_ctrl;

    localparam int unsigned ADDR_W = 17;
    localparam int unsigned DATA_W = 24;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              if_read_enable = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic              if_is_mem = 1'b0;
    logic              mem_read_enable = 1'b0;
    logic              mem_write_enable = 1'b0;
    logic [ADDR_W-1:0] mem_addr = '0;
    logic [DATA_W-1:0] mem_wdata = '0;
    logic [DATA_W-1:0] if_data, mem_rdata, sram_dq_o;
    logic [DATA_W-1:0] sram_dq_i = '0;
    logic [ADDR_W-1:0] sram_addr_o;
    logic              if_data_ready, mem_data_ready, busy;
    logic              sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe;

    int n_checks = 0;
    int n_errors = 0;

    candy_sram_ctrl #(
        .WAIT_CYCLES (2),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .if_read_enable   (if_read_enable),
        .if_addr          (if_addr),
        .if_is_mem        (if_is_mem),
        .mem_read_enable  (mem_read_enable),
        .mem_write_enable (mem_write_enable),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .if_data          (if_data),
        .if_data_ready    (if_data_ready),
        .mem_rdata        (mem_rdata),
        .mem_data_ready   (mem_data_ready),
        .busy             (busy),
        .sram_addr_o      (sram_addr_o),
        .sram_ce_n        (sram_ce_n),
        .sram_oe_n        (sram_oe_n),
        .sram_we_n        (sram_we_n),
        .sram_dq_i        (sram_dq_i),
        .sram_dq_o        (sram_dq_o),
        .sram_dq_oe       (sram_dq_oe)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        check_val("rst_ce_n", 32'(sram_ce_n), 32'h1);
        check_val("rst_oe_n", 32'(sram_oe_n), 32'h1);
        check_val("rst_we_n", 32'(sram_we_n), 32'h1);
        check_val("rst_dq_oe", 32'(sram_dq_oe), 32'h0);
        check_val("rst_busy", 32'(busy), 32'h0);
        check_val("rst_rdy", 32'({if_data_ready, mem_data_ready}), 32'h0);
        check_val("rst_addr", 32'(sram_addr_o), 32'h0);
        check_val("rst_data", 32'(if_data | mem_rdata | sram_dq_o), 32'h0);
        step();
        rst = 1'b1;
        step();

        // Fetch read
        if_read_enable = 1'b1; if_addr = 17'h012; sram_dq_i = 24'h027890;
        check_val("if_idle_oe_n", 32'(sram_oe_n), 32'h1);
        step();
        check_val("if_rd1_oe_n", 32'(sram_oe_n), 32'h0);
        check_val("if_rd1_addr", 32'(sram_addr_o), 32'h012);
        check_val("if_rd1_busy", 32'(busy), 32'h1);
        check_val("if_rd1_rdy", 32'(if_data_ready), 32'h0);
        step();
        check_val("if_rd2_oe_n", 32'(sram_oe_n), 32'h0);
        check_val("if_rd2_rdy", 32'(if_data_ready), 32'h0);
        step();
        check_val("if_done_rdy", 32'(if_data_ready), 32'h1);
        check_val("if_done_data", 32'(if_data), 32'h027890);
        check_val("if_done_ce_n", 32'(sram_ce_n), 32'h1);
        check_val("if_done_oe_n", 32'(sram_oe_n), 32'h1);
        if_read_enable = 1'b0;
        step();
        check_val("if_idle_rdy", 32'(if_data_ready), 32'h0);
        check_val("if_idle_busy", 32'(busy), 32'h0);

        // Write
        mem_write_enable = 1'b1; mem_addr = 17'h1F000; mem_wdata = 24'hABCDEF;
        step();
        check_val("wr1_we_n", 32'(sram_we_n), 32'h0);
        check_val("wr1_oe_n", 32'(sram_oe_n), 32'h1);
        check_val("wr1_dq_oe", 32'(sram_dq_oe), 32'h1);
        check_val("wr1_dq_o", 32'(sram_dq_o), 32'hABCDEF);
        check_val("wr1_addr", 32'(sram_addr_o), 32'h1F000);
        step();
        check_val("wr2_we_n", 32'(sram_we_n), 32'h1);
        check_val("wr2_dq_oe", 32'(sram_dq_oe), 32'h1);
        check_val("wr2_ce_n", 32'(sram_ce_n), 32'h0);
        check_val("wr2_addr", 32'(sram_addr_o), 32'h1F000);
        step();
        check_val("wr_done_mrdy", 32'(mem_data_ready), 32'h1);
        check_val("wr_done_irdy", 32'(if_data_ready), 32'h0);
        check_val("wr_done_dq_oe", 32'(sram_dq_oe), 32'h0);
        mem_write_enable = 1'b0;
        step();
        check_val("wr_idle_mrdy", 32'(mem_data_ready), 32'h0);

        // Simultaneous MEM and IF reads: MEM first
        mem_read_enable = 1'b1; mem_addr = 17'h00ABC;
        if_read_enable = 1'b1; if_addr = 17'h00DEF; sram_dq_i = 24'h111111;
        step();
        check_val("arb_mem_addr", 32'(sram_addr_o), 32'h00ABC);
        step();
        step();
        check_val("arb_mem_rdy", 32'(mem_data_ready), 32'h1);
        check_val("arb_mem_irdy", 32'(if_data_ready), 32'h0);
        check_val("arb_mem_data", 32'(mem_rdata), 32'h111111);
        check_val("arb_if_hold", 32'(if_data), 32'h027890);
        mem_read_enable = 1'b0; sram_dq_i = 24'h222222;
        step();
        check_val("arb_gap_busy", 32'(busy), 32'h0);
        step();
        check_val("arb_if_addr", 32'(sram_addr_o), 32'h00DEF);
        step();
        step();
        check_val("arb_if_rdy", 32'(if_data_ready), 32'h1);
        check_val("arb_if_data", 32'(if_data), 32'h222222);
        check_val("arb_mem_hold", 32'(mem_rdata), 32'h111111);
        if_read_enable = 1'b0;
        step();

        // Fetch blocked by if_is_mem
        if_read_enable = 1'b1; if_is_mem = 1'b1; if_addr = 17'h00321; sram_dq_i = 24'h333333;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("ismem_busy", 32'(busy), 32'h0);
            check_val("ismem_ce_n", 32'(sram_ce_n), 32'h1);
        end
        if_is_mem = 1'b0;
        step();
        check_val("ismem_rel_busy", 32'(busy), 32'h1);
        check_val("ismem_rel_addr", 32'(sram_addr_o), 32'h00321);
        step();
        step();
        check_val("ismem_rdy", 32'(if_data_ready), 32'h1);
        check_val("ismem_data", 32'(if_data), 32'h333333);
        if_read_enable = 1'b0;
        step();

        // Reset in the middle of a read
        mem_read_enable = 1'b1; mem_addr = 17'h00055; sram_dq_i = 24'h555555;
        step();
        check_val("arst_pre_oe_n", 32'(sram_oe_n), 32'h0);
        #2;
        rst = 1'b0;
        #1;
        check_val("arst_busy", 32'(busy), 32'h0);
        check_val("arst_oe_n", 32'(sram_oe_n), 32'h1);
        check_val("arst_ce_n", 32'(sram_ce_n), 32'h1);
        check_val("arst_addr", 32'(sram_addr_o), 32'h0);
        check_val("arst_data", 32'(if_data | mem_rdata), 32'h0);
        mem_read_enable = 1'b0;
        step();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_val("arst_no_rdy", 32'({if_data_ready, mem_data_ready}), 32'h0);
        end
        if_read_enable = 1'b1; if_addr = 17'h00001; sram_dq_i = 24'h444444;
        step();
        step();
        step();
        check_val("arst_next_rdy", 32'(if_data_ready), 32'h1);
        check_val("arst_next_data", 32'(if_data), 32'h444444);
        if_read_enable = 1'b0;
        step();

        // Read and write together: write wins, single ready
        mem_read_enable = 1'b1; mem_write_enable = 1'b1;
        mem_addr = 17'h00077; mem_wdata = 24'h5A5A5A; sram_dq_i = 24'h777777;
        step();
        check_val("rw_we_n", 32'(sram_we_n), 32'h0);
        check_val("rw_oe_n", 32'(sram_oe_n), 32'h1);
        check_val("rw_dq_o", 32'(sram_dq_o), 32'h5A5A5A);
        step();
        step();
        check_val("rw_done_rdy", 32'(mem_data_ready), 32'h1);
        check_val("rw_rdata", 32'(mem_rdata), 32'h0);
        mem_read_enable = 1'b0; mem_write_enable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check_val("rw_single_rdy", 32'(mem_data_ready), 32'h0);
        end
        check_val("rw_end_busy", 32'(busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
